// File: rtl/log2_pkg.sv
// rtl/log2_pkg.sv - shared constants and helpers for the log2 approximation pipeline
package log2_pkg;

   localparam logic MODE_MITCHELL = 1'b0;
   localparam logic MODE_CORR     = 1'b1;

   // Right shift applied to the distance from the nearest integer in mode 1
   localparam int CORR_SHIFT = 3;

   // Most negative two's-complement value of a w-bit word (1 followed by zeros)
   function automatic logic [63:0] min_signed(input int w);
      return 64'd1 << (w - 1);
   endfunction

endpackage

// File: rtl/leading_one_detect.sv
// rtl/leading_one_detect.sv - combinational index of the most significant set bit
module leading_one_detect #(
   parameter int W = 16,
   localparam int PW = (W > 1) ? $clog2(W) : 1
) (
   input  logic [W-1:0]  data,
   output logic [PW-1:0] pos,
   output logic          zero
);

   // Scan upward so the highest set bit wins; pos is 0 when data is all zero
   always_comb begin
      pos = '0;
      for (int i = 0; i < W; i++) begin
         if (data[i]) pos = PW'(i);
      end
      zero = (data == '0);
   end

endmodule

// File: rtl/log2_approx_pipe.sv
// rtl/log2_approx_pipe.sv - three-stage handshaked Mitchell log2 with optional correction
module log2_approx_pipe
   import log2_pkg::*;
#(
   parameter int W        = 16,
   parameter int IN_FRAC  = 12,
   parameter int OUT_FRAC = 12,
   parameter int SB_W     = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [W-1:0]    in_data,
   input  logic            in_mode,
   input  logic [SB_W-1:0] in_sb,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [W-1:0]    out_log,
   output logic            out_zero,
   output logic            out_sat,
   output logic [SB_W-1:0] out_sb
);

   localparam int PW = $clog2(W);
   localparam int IW = W - OUT_FRAC;
   localparam logic [W-1:0] MIN_VAL = W'(min_signed(W));

   // The largest integer part of the input must fit the signed integer field of the output
   if (W - IN_FRAC > 2 ** (IW - 1)) begin : g_range_check
      $error("log2_approx_pipe: integer range of input exceeds output");
   end

   logic            s0_v, s1_v, s2_v;
   logic [W-1:0]    s0_data, s1_data;
   logic            s0_mode, s1_mode;
   logic [SB_W-1:0] s0_sb, s1_sb, s2_sb;
   logic [PW-1:0]   s1_pos;
   logic            s1_zero;
   logic [W-1:0]    s2_log;
   logic            s2_zero, s2_sat;

   logic            s0_free, s1_free, s2_free;
   logic [PW-1:0]   lod_pos;
   logic            lod_zero;

   logic [W-1:0]          shifted;
   logic [W+OUT_FRAC-1:0] ext;
   logic [OUT_FRAC-1:0]   f, f_neg, c;
   int                    e, sum;
   logic [W-1:0]          asm_log;
   logic                  asm_sat;

   // A stage may take new data when it is empty or its content moves on this cycle
   assign s2_free  = !s2_v || out_ready;
   assign s1_free  = !s1_v || s2_free;
   assign s0_free  = !s0_v || s1_free;
   assign in_ready = s0_free;

   leading_one_detect #(.W(W)) u_lod (
      .data (s0_data),
      .pos  (lod_pos),
      .zero (lod_zero)
   );

   // Fraction extraction, optional correction and result assembly from the S1 registers
   always_comb begin
      // Put the leading one at the top, then take the OUT_FRAC bits just below it (zero-filled)
      shifted = s1_data << (W - 1 - int'(s1_pos));
      ext     = {shifted, {OUT_FRAC{1'b0}}};
      f       = OUT_FRAC'(ext >> (W - 1));
      // Modulo 2^OUT_FRAC negation equals 2^OUT_FRAC - f whenever f is in the upper half
      f_neg   = -f;
      if (f[OUT_FRAC-1] == 1'b0) c = f >> CORR_SHIFT;
      else                       c = f_neg >> CORR_SHIFT;
      e       = int'(s1_pos) - IN_FRAC;
      sum     = (e <<< OUT_FRAC) + int'(f) + ((s1_mode == MODE_CORR) ? int'(c) : 0);
      asm_log = W'(sum);
      asm_sat = (e < -(2 ** (IW - 1)));
      if (s1_zero) begin
         asm_log = MIN_VAL;
         asm_sat = 1'b0;
      end else if (asm_sat) begin
         asm_log = MIN_VAL;
      end
   end

   // S0: capture the accepted input sample
   always_ff @(posedge clk) begin
      if (rst) begin
         s0_v    <= 1'b0;
         s0_data <= '0;
         s0_mode <= 1'b0;
         s0_sb   <= '0;
      end else if (s0_free) begin
         s0_v <= in_valid;
         if (in_valid) begin
            s0_data <= in_data;
            s0_mode <= in_mode;
            s0_sb   <= in_sb;
         end
      end
   end

   // S1: register the leading-one position alongside the raw sample
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_v    <= 1'b0;
         s1_data <= '0;
         s1_mode <= 1'b0;
         s1_sb   <= '0;
         s1_pos  <= '0;
         s1_zero <= 1'b0;
      end else if (s1_free) begin
         s1_v <= s0_v;
         if (s0_v) begin
            s1_data <= s0_data;
            s1_mode <= s0_mode;
            s1_sb   <= s0_sb;
            s1_pos  <= lod_pos;
            s1_zero <= lod_zero;
         end
      end
   end

   // S2: output register, held while downstream stalls
   always_ff @(posedge clk) begin
      if (rst) begin
         s2_v    <= 1'b0;
         s2_log  <= '0;
         s2_zero <= 1'b0;
         s2_sat  <= 1'b0;
         s2_sb   <= '0;
      end else if (s2_free) begin
         s2_v <= s1_v;
         if (s1_v) begin
            s2_log  <= asm_log;
            s2_zero <= s1_zero;
            s2_sat  <= asm_sat;
            s2_sb   <= s1_sb;
         end
      end
   end

   assign out_valid = s2_v;
   assign out_log   = s2_log;
   assign out_zero  = s2_zero;
   assign out_sat   = s2_sat;
   assign out_sb    = s2_sb;

endmodule

// File: tb/tb_log2_approx_pipe.sv
// tb/tb_log2_approx_pipe.sv - directed and randomised checks of log2_approx_pipe
module tb_log2_approx_pipe;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_data = '0;
   logic        in_mode = 1'b0;
   logic [31:0] in_sb = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] out_log;
   logic        out_zero;
   logic        out_sat;
   logic [31:0] out_sb;

   int errors = 0;
   int checks = 0;
   int n_out  = 0;
   int cyc    = 0;
   logic [63:0] cur_exp = '0;
   logic [63:0] got;
   logic [63:0] expq[$];

   log2_approx_pipe #(.W(16), .IN_FRAC(12), .OUT_FRAC(12), .SB_W(32)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_mode(in_mode), .in_sb(in_sb),
      .out_valid(out_valid), .out_ready(out_ready), .out_log(out_log),
      .out_zero(out_zero), .out_sat(out_sat), .out_sb(out_sb)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] mk(input logic [15:0] lg, input logic z, input logic s,
                                      input logic [31:0] sb);
      return {14'd0, sb, z, s, lg};
   endfunction

   // Reference: f = (x - 2^p) * 2^12 / 2^p truncated, result = e*4096 + f (+ c)
   function automatic logic [63:0] model(input logic [15:0] x, input logic m, input logic [31:0] sb);
      int p, e, f, c, r;
      if (x == 16'd0) return mk(16'h8000, 1'b1, 1'b0, sb);
      p = 15;
      while (!x[p]) p--;
      e = p - 12;
      if (e < -8) return mk(16'h8000, 1'b0, 1'b1, sb);
      f = ((int'(x) - (1 << p)) * 4096) >> p;
      c = 0;
      if (m) c = (f < 2048) ? f / 8 : (4096 - f) / 8;
      r = e * 4096 + f + c;
      return mk(r[15:0], 1'b0, 1'b0, sb);
   endfunction

   // Scoreboard: handshakes are sampled on the falling edge ahead of the rising edge that commits them
   always @(negedge clk) begin
      if (rst) begin
         expq.delete();
      end else begin
         if (out_valid && out_ready) begin
            if (expq.size() == 0) begin
               chk("unexpected_out", 64'd1, 64'd0);
            end else begin
               got = mk(out_log, out_zero, out_sat, out_sb);
               chk("out", got, expq.pop_front());
               n_out++;
            end
         end
         if (in_valid && in_ready) expq.push_back(cur_exp);
      end
   end

   task automatic set_in(input logic [15:0] d, input logic m, input logic [31:0] sb,
                         input logic [63:0] exp);
      in_data  = d;
      in_mode  = m;
      in_sb    = sb;
      cur_exp  = exp;
      in_valid = 1'b1;
   endtask

   // Called at posedge+1; returns at posedge+1 after the accepting edge
   task automatic wait_acc();
      int g = 0;
      logic acc;
      do begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         g++;
      end while (!acc && g < 200);
      if (!acc) chk("accept_timeout", 64'd0, 64'd1);
      in_valid = 1'b0;
   endtask

   task automatic push(input logic [15:0] d, input logic m, input logic [31:0] sb,
                       input logic [63:0] exp);
      set_in(d, m, sb, exp);
      wait_acc();
   endtask

   task automatic drain();
      int g = 0;
      do begin
         @(posedge clk);
         #1;
         g++;
      end while (expq.size() != 0 && g < 200);
      chk("drain_left", 64'(expq.size()), 64'd0);
   endtask

   task automatic lat_test(input logic [15:0] d, input logic [15:0] lg, input logic [31:0] sb);
      int lat = 1;
      push(d, 1'b0, sb, mk(lg, 1'b0, 1'b0, sb));
      forever begin
         @(negedge clk);
         if (out_valid || lat >= 10) break;
         @(posedge clk);
         #1;
         lat++;
      end
      chk("latency", 64'(lat), 64'd3);
      drain();
   endtask

   logic [15:0] bp_d [8] = '{16'h1000, 16'h2000, 16'h4000, 16'h8000,
                             16'h0800, 16'h0400, 16'h1800, 16'h3000};
   logic [15:0] bp_r [8] = '{16'h0000, 16'h1000, 16'h2000, 16'h3000,
                             16'hF000, 16'hE000, 16'h0800, 16'h1800};

   initial begin
      logic [15:0] hold_log;
      logic [31:0] hold_sb;
      logic [15:0] x;
      logic        rm;
      bit          done;
      int          n0, c0;

      // Reset state
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_outs", mk(out_log, out_zero, out_sat, out_sb), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      out_ready = 1'b1;

      // Plain Mitchell with latency measurement
      lat_test(16'h1000, 16'h0000, 32'hA1);
      lat_test(16'h8000, 16'h3000, 32'hA2);
      lat_test(16'h1800, 16'h0800, 32'hA3);

      // Corrected mode
      push(16'h1800, 1'b1, 32'hB1, mk(16'h0900, 1'b0, 1'b0, 32'hB1));
      push(16'h1400, 1'b1, 32'hB2, mk(16'h0480, 1'b0, 1'b0, 32'hB2));
      push(16'h1000, 1'b1, 32'hB3, mk(16'h0000, 1'b0, 1'b0, 32'hB3));
      drain();

      // Boundaries: zero, exact minimum, underflow, full scale
      push(16'h0000, 1'b1, 32'hC1, mk(16'h8000, 1'b1, 1'b0, 32'hC1));
      push(16'h0010, 1'b0, 32'hC2, mk(16'h8000, 1'b0, 1'b0, 32'hC2));
      push(16'h000F, 1'b0, 32'hC3, mk(16'h8000, 1'b0, 1'b1, 32'hC3));
      push(16'hFFFF, 1'b0, 32'hC4, mk(16'h3FFF, 1'b0, 1'b0, 32'hC4));
      drain();

      // Backpressure: fill three stages with the output stalled
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++)
         push(bp_d[i], 1'b0, 32'h100 + i, mk(bp_r[i], 1'b0, 1'b0, 32'h100 + i));
      set_in(bp_d[3], 1'b0, 32'h103, mk(bp_r[3], 1'b0, 1'b0, 32'h103));
      @(negedge clk);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_first_sb", 64'(out_sb), 64'h100);
      hold_log = out_log;
      hold_sb  = out_sb;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk);
         #1;
         @(negedge clk);
         chk("bp_hold_ready", 64'(in_ready), 64'd0);
         chk("bp_hold_out", {out_valid, out_log, out_sb}, {1'b1, hold_log, hold_sb});
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      wait_acc();
      for (int i = 4; i < 8; i++)
         push(bp_d[i], 1'b0, 32'h100 + i, mk(bp_r[i], 1'b0, 1'b0, 32'h100 + i));
      drain();

      // Random valid/ready traffic against the model
      n0 = n_out;
      done = 1'b0;
      fork
         begin
            for (int i = 0; i < 1000; i++) begin
               if ($urandom_range(0, 3) == 0) begin
                  @(posedge clk);
                  #1;
               end
               case ($urandom_range(0, 3))
                  0:       x = 16'($urandom);
                  1:       x = 16'($urandom) >> $urandom_range(0, 15);
                  2:       x = 16'($urandom_range(0, 31));
                  default: x = 16'h8000 >> $urandom_range(0, 15);
               endcase
               rm = 1'($urandom_range(0, 1));
               push(x, rm, 32'h10000 + i, model(x, rm, 32'h10000 + i));
            end
            done = 1'b1;
         end
         begin
            while (!done) begin
               out_ready = ($urandom_range(0, 2) != 0);
               @(posedge clk);
               #1;
            end
            out_ready = 1'b1;
         end
      join
      drain();
      chk("rand_count", 64'(n_out - n0), 64'd1000);

      // Back-to-back streaming at full rate
      n0 = n_out;
      c0 = cyc;
      for (int i = 0; i < 20; i++) begin
         x = 16'h0100 + 16'(i * 16'h0333);
         push(x, 1'b1, 32'h200 + i, model(x, 1'b1, 32'h200 + i));
      end
      chk("b2b_cycles", 64'(cyc - c0), 64'd20);
      drain();
      chk("b2b_count", 64'(n_out - n0), 64'd20);

      // Reset with three samples in flight
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++)
         push(16'h4000, 1'b0, 32'hDEAD0 + i, mk(16'h2000, 1'b0, 1'b0, 32'hDEAD0 + i));
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
      chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
      chk("mid_rst_outs", mk(out_log, out_zero, out_sat, out_sb), 64'd0);
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      n0 = n_out;
      push(16'h2000, 1'b0, 32'hE1, mk(16'h1000, 1'b0, 1'b0, 32'hE1));
      drain();
      repeat (10) @(posedge clk);
      #1;
      chk("post_rst_count", 64'(n_out - n0), 64'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/log2_approx_pipe.md
Name: log2_approx_pipe

Overview:
- Parametrised, handshaked successor to the team's fixed Q4.12 stage-1 log2 approximator.
- Computes a Mitchell leading-one log2 of an unsigned fixed-point input, with an optional per-sample piecewise-linear error correction.
- Detects zero and underflow inputs, and carries an opaque sideband word aligned with the result.
- Sits at the front of the softmax datapath and adds valid/ready backpressure, which the previous generation lacked.

Parameters:
- W, 16, input and output word width.
- IN_FRAC, 12, fractional bits of the unsigned input.
- OUT_FRAC, 12, fractional bits of the signed two's-complement output.
- SB_W, 32, sideband width, passed through unchanged (e.g. the original inputs as bypass).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample this cycle.
- in_data  in  W  unsigned input, Q(W-IN_FRAC).IN_FRAC.
- in_mode  in  1  0 = plain Mitchell, 1 = corrected; sampled with the data.
- in_sb  in  SB_W  sideband.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- out_log  out  W  log2 result, signed Q(W-OUT_FRAC).OUT_FRAC.
- out_zero  out  1  input was 0.
- out_sat  out  1  result clamped to the minimum value.
- out_sb  out  SB_W  sideband aligned with out_log.

Behaviour:
- Pipeline stages:
  - S0 registers the input.
  - S1 performs leading-one detection: pos = index of the MSB set, int = pos - IN_FRAC.
  - S2 shifts and assembles the result, then registers it.
- Latency is 3 cycles from the in_valid&&in_ready edge to out_valid when there is no stall.
- Handshake:
  - Each stage holds a valid bit.
  - A stage loads when it is empty or the next stage loads this cycle; S2 "unloads" when out_valid&&out_ready.
  - in_ready = S0 empty OR S0 loads. The ready chain is combinational and bubbles collapse.
  - Throughput is 1 sample per cycle.
- Under stall, all out_* signals stay stable. No sample is dropped or duplicated, and order is preserved.
- Capacity is 3 samples. in_ready drops only when all 3 stages are full and out_ready=0.
- Fraction f: take the OUT_FRAC bits immediately below the leading one, MSB-aligned and zero-filled. Truncate; no rounding.
- Mode 1 correction:
  - If f < 2^(OUT_FRAC-1): c = f>>3; otherwise c = (2^OUT_FRAC - f)>>3.
  - f + c never carries into the integer part.
- Result = (int << OUT_FRAC) + f (+ c in mode 1), in W-bit two's complement.
- Saturation:
  - When int < -2^(W-OUT_FRAC-1), out_log = 1 followed by W-1 zeros and out_sat=1.
  - Positive overflow is impossible when W-IN_FRAC <= 2^(W-OUT_FRAC-1); this is an elaboration-time check.
- Zero input: out_log = minimum value, out_zero=1, out_sat=0, mode ignored.
- Reset (any cycle, including mid-stream):
  - All stage valid bits clear and all data registers go to 0.
  - Next cycle: out_valid=0, out_log=0, out_zero=0, out_sat=0, out_sb=0, in_ready=1.
  - In-flight samples are discarded.
- Simultaneous in_valid and out_ready with a full pipe: the input is accepted and S2 unloads in the same cycle.

Decomposition:
- Package log2_pkg holds:
  - the mode encodings MODE_MITCHELL=0 and MODE_CORR=1;
  - the correction shift constant CORR_SHIFT=3;
  - a function that returns the minimum signed value for a given W.
- One sub-module, leading_one_detect (W parameter): combinational, outputs pos and an all-zero flag. It is used in S1.

Test Plan:
1. Defaults, mode 0, out_ready=1:
   - 0x1000 -> 0x0000.
   - 0x8000 -> 0x3000.
   - 0x1800 -> 0x0800.
   - Each result appears exactly 3 cycles after acceptance.
2. Mode 1:
   - 0x1800 -> 0x0900 (f=0x800, c=0x100).
   - 0x1400 -> 0x0480 (f=0x400, c=0x080).
   - 0x1000 -> 0x0000.
3. Boundaries:
   - 0x0000 -> 0x8000, zero=1.
   - 0x0010 -> 0x8000, sat=0 (int=-8, exact).
   - 0x000F -> 0x8000, sat=1.
   - 0xFFFF -> 0x3FFF.
4. Backpressure:
   - Stream 8 samples with distinct in_sb, out_ready=0 for cycles 2-7.
   - in_ready falls after 3 accepted samples; outputs stay stable.
   - After release, all 8 results emerge in order with their matching sideband.
5. Random valid/ready toggling, 1000 samples, checked against a reference model:
   - No loss or duplication.
   - Back-to-back 1 sample/cycle when both sides are always 1.
6. Reset asserted with 3 samples in flight:
   - Next cycle out_valid=0, in_ready=1.
   - No stale result appears afterwards.
   - The first post-reset sample 0x2000 -> 0x1000.
